mtimer_slave: RTL and testbench
===============================

Name: mtimer_slave

Overview:
- Memory-mapped RISC-V machine timer, a responder on the CPU data bus, decoded at its own base address.
- Holds a 64-bit free-running mtime counter with a programmable prescaler and a 64-bit mtimecmp register.
- Drives the processor's timer_irq input.
- Byte-addressed register interface with 1-cycle registered read data, matching the interconnect's registered read-select.

Parameters:
ADDR_WIDTH, 8, byte-offset width of the register window (256 B).
PRESC_WIDTH, 16, prescaler register width.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_we  input  1  write enable, one transfer per cycle
i_waddr  input  ADDR_WIDTH  write byte offset; bits [1:0] ignored
i_wdata  input  32  write data
i_wstrb  input  4  byte-lane write enables
i_re  input  1  read enable
i_raddr  input  ADDR_WIDTH  read byte offset; bits [1:0] ignored
o_rdata  output  32  read data, valid the cycle after i_re
o_timer_irq  output  1  level timer interrupt to CPU

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Register map (word offsets, decoded on addr[ADDR_WIDTH-1:2]):
  - 0x00 CTRL: bit0 EN; other bits read 0.
  - 0x04 PRESC: [PRESC_WIDTH-1:0].
  - 0x08 MTIME_LO.
  - 0x0C MTIME_HI: reads the shadow register.
  - 0x10 MTIMECMP_LO.
  - 0x14 MTIMECMP_HI.
  - 0x18 STATUS: bit0 = (mtime >= mtimecmp), read-only.
  - Unmapped offsets: read 0, writes ignored.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, EN = 0, PRESC = 0.
  - Prescaler count = 0, shadow_hi = 0.
  - o_rdata = 0, o_timer_irq = 0.
  - rst mid-operation overrides any write or tick in the same cycle.
- Writes:
  - Take effect at the clk edge where i_we = 1.
  - Byte lane k is updated only if i_wstrb[k] = 1. i_wstrb = 0 is a no-op.
- Read latency: o_rdata is registered on the edge where i_re = 1 and is valid the following cycle.
- o_rdata holds its last value when i_re = 0.
- Read and write to the same register in the same cycle: the read returns the pre-write value.
- Atomic 64-bit read: a read of MTIME_LO also loads shadow_hi with mtime[63:32] from the same edge (pre-increment). A later MTIME_HI read returns shadow_hi.
- Prescaler:
  - While EN = 1, the count increments each cycle.
  - When count == PRESC, count returns to 0 and mtime increments by 1. PRESC = 0 therefore gives a tick every cycle.
  - EN = 0 holds the count at 0 and holds mtime.
  - A write to PRESC or to CTRL clears the count.
- mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
- A write to MTIME_LO or MTIME_HI in the same cycle as a tick: the write wins on written bytes and the tick is discarded for that cycle. The unwritten half keeps its pre-tick value, with no carry.
- Compare is unsigned 64-bit.
- o_timer_irq is registered: o_timer_irq <= EN & (mtime >= mtimecmp), using values before the edge. It therefore lags a state change by 1 cycle.
- The interrupt is cleared only by raising mtimecmp or clearing EN; there is no sticky pending bit.
- Software updating mtimecmp with two 32-bit writes may see a transient irq. Recommended sequence: MTIMECMP_HI = all-ones, then LO, then HI.

Decomposition:
- Shared package mtimer_pkg:
  - Register word offsets (CTRL..STATUS).
  - CTRL bit index.
  - mtimecmp reset constant.
  - Default ADDR_WIDTH.
- One sub-module: mtimer_prescaler (EN, PRESC, clear in → single-cycle tick out).
- Register file, shadow, compare and read mux stay in mtimer_slave.

Test Plan:
- Reset then read all offsets 0x00–0x1C:
  - Expect 0, 0, 0, 0, FFFFFFFF, FFFFFFFF, 0, 0.
  - o_timer_irq = 0.
- Prescaler: PRESC = 3, CTRL = 1, wait 40 cycles, read MTIME_LO → 10 (±1 depending on write-to-enable alignment, checked exactly against the model). Then CTRL = 0 and two reads 20 cycles apart are equal.
- Wrap and atomic read: write MTIME_HI = FFFFFFFF and MTIME_LO = FFFFFFFE, PRESC = 0, EN = 1.
  - Read LO, then HI on the next cycle.
  - The HI value must match the shadow taken at the LO read, not the wrapped mtime.
  - Later reads show mtime = 0x0000_0000_0000_000x.
- Compare: mtime = 0, MTIMECMP_HI = 0, MTIMECMP_LO = 5, PRESC = 0, EN = 1.
  - o_timer_irq rises exactly 1 cycle after mtime reaches 5.
  - Writing MTIMECMP_LO = FFFFFFFF and MTIMECMP_HI = FFFFFFFF deasserts it 1 cycle later.
  - STATUS.bit0 tracks the raw compare.
- Byte strobes: write MTIMECMP_LO = 0xAABBCCDD with wstrb = 4'b0101 over FFFFFFFF → readback 0xFFBBFFDD. wstrb = 0 causes no change.
- Collisions:
  - Write MTIME_LO = 0x100 in a tick cycle → reads 0x100 then increments.
  - Simultaneous read and write of PRESC returns the old value.
  - rst asserted mid-count restores all reset values on the next edge.

Source files
------------

// File: rtl/mtimer_pkg.sv
// Shared constants for the memory-mapped machine timer: register byte offsets,
// control bit positions, reset values and the byte-lane merge helper.
package mtimer_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 8;

    localparam int REG_CTRL        = 'h00;
    localparam int REG_PRESC       = 'h04;
    localparam int REG_MTIME_LO    = 'h08;
    localparam int REG_MTIME_HI    = 'h0C;
    localparam int REG_MTIMECMP_LO = 'h10;
    localparam int REG_MTIMECMP_HI = 'h14;
    localparam int REG_STATUS      = 'h18;

    localparam int CTRL_EN_BIT = 0;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides the clock by (presc_i + 1) while enabled, emitting a one-cycle tick
// in the cycle where the count matches the divisor.
module mtimer_prescaler
    import mtimer_pkg::*;
#(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    input  logic                   clr_i,
    output logic                   tick_o
);

    logic [PRESC_WIDTH-1:0] cnt_q;
    logic [PRESC_WIDTH-1:0] cnt_d;

    // The tick depends only on pre-edge state, so a clear in the same cycle
    // restarts the count without swallowing a tick already due.
    assign tick_o = en_i & (cnt_q == presc_i);

    always_comb begin
        cnt_d = cnt_q + PRESC_WIDTH'(1);
        if (!en_i || clr_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mtimer_slave.sv
// RISC-V machine timer responder: 64-bit mtime with prescaler, 64-bit
// mtimecmp, registered level interrupt and a byte-strobed register window.
module mtimer_slave
    import mtimer_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [31:0]           o_rdata,
    output logic                  o_timer_irq
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(REG_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_PRESC  = ADDR_WIDTH'(REG_PRESC);
    localparam logic [ADDR_WIDTH-1:0] A_MT_LO  = ADDR_WIDTH'(REG_MTIME_LO);
    localparam logic [ADDR_WIDTH-1:0] A_MT_HI  = ADDR_WIDTH'(REG_MTIME_HI);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_LO = ADDR_WIDTH'(REG_MTIMECMP_LO);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_HI = ADDR_WIDTH'(REG_MTIMECMP_HI);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(REG_STATUS);

    // Bus contract: no backpressure. A write with i_we=1 commits at that edge;
    // a read with i_re=1 returns data on o_rdata the next cycle, which then
    // holds until the next read. A nonzero-strobe write is the only "write".
    logic [ADDR_WIDTH-3:0] wword, rword;
    logic                  wr_any;
    logic                  wr_ctrl, wr_presc, wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi;
    logic                  rd_mt_lo;
    logic                  tick, cmp_hit;
    logic [31:0]           rd_val;

    logic                   en_q, en_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [63:0]            mtime_q, mtime_d;
    logic [63:0]            cmp_q, cmp_d;
    logic [31:0]            shadow_q, shadow_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   irq_q, irq_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_waddr[1:0], i_raddr[1:0]};

    assign wword     = i_waddr[ADDR_WIDTH-1:2];
    assign rword     = i_raddr[ADDR_WIDTH-1:2];
    assign wr_any    = i_we & (|i_wstrb);
    assign wr_ctrl   = wr_any & (wword == A_CTRL[ADDR_WIDTH-1:2]);
    assign wr_presc  = wr_any & (wword == A_PRESC[ADDR_WIDTH-1:2]);
    assign wr_mt_lo  = wr_any & (wword == A_MT_LO[ADDR_WIDTH-1:2]);
    assign wr_mt_hi  = wr_any & (wword == A_MT_HI[ADDR_WIDTH-1:2]);
    assign wr_cmp_lo = wr_any & (wword == A_CMP_LO[ADDR_WIDTH-1:2]);
    assign wr_cmp_hi = wr_any & (wword == A_CMP_HI[ADDR_WIDTH-1:2]);
    assign rd_mt_lo  = i_re & (rword == A_MT_LO[ADDR_WIDTH-1:2]);

    assign cmp_hit = (mtime_q >= cmp_q);

    mtimer_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_presc (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_q),
        .presc_i (presc_q),
        .clr_i   (wr_ctrl | wr_presc),
        .tick_o  (tick)
    );

    always_comb begin
        rd_val = '0;
        case (rword)
            A_CTRL[ADDR_WIDTH-1:2]:   rd_val[CTRL_EN_BIT] = en_q;
            A_PRESC[ADDR_WIDTH-1:2]:  rd_val[PRESC_WIDTH-1:0] = presc_q;
            A_MT_LO[ADDR_WIDTH-1:2]:  rd_val = mtime_q[31:0];
            A_MT_HI[ADDR_WIDTH-1:2]:  rd_val = shadow_q;
            A_CMP_LO[ADDR_WIDTH-1:2]: rd_val = cmp_q[31:0];
            A_CMP_HI[ADDR_WIDTH-1:2]: rd_val = cmp_q[63:32];
            A_STATUS[ADDR_WIDTH-1:2]: rd_val[0] = cmp_hit;
            default:                  rd_val = '0;
        endcase
    end

    always_comb begin
        en_d     = en_q;
        presc_d  = presc_q;
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        irq_d    = en_q & cmp_hit;
        mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;

        if (wr_ctrl && i_wstrb[0]) en_d = i_wdata[CTRL_EN_BIT];
        if (wr_presc) begin
            for (int b = 0; b < PRESC_WIDTH; b++) begin
                if (i_wstrb[b/8]) presc_d[b] = i_wdata[b];
            end
        end
        // A software write to mtime discards any tick; the other half is not carried into.
        if (wr_mt_lo) mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_wdata, i_wstrb)};
        if (wr_mt_hi) mtime_d = {merge_bytes(mtime_q[63:32], i_wdata, i_wstrb), mtime_q[31:0]};
        if (wr_cmp_lo) cmp_d[31:0]  = merge_bytes(cmp_q[31:0], i_wdata, i_wstrb);
        if (wr_cmp_hi) cmp_d[63:32] = merge_bytes(cmp_q[63:32], i_wdata, i_wstrb);

        if (i_re) rdata_d = rd_val;
        if (rd_mt_lo) shadow_d = mtime_q[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            presc_q  <= '0;
            mtime_q  <= '0;
            cmp_q    <= MTIMECMP_RST;
            shadow_q <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            presc_q  <= presc_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign o_rdata     = rdata_q;
    assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_mtimer_slave.sv
// Directed and randomized bench for mtimer_slave with a cycle-level reference
// model of the timer's register semantics.
module tb_mtimer_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_we = 1'b0;
    logic [7:0]  i_waddr = '0;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_wstrb = '0;
    logic        i_re = 1'b0;
    logic [7:0]  i_raddr = '0;
    logic [31:0] o_rdata;
    logic        o_timer_irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_en;
    logic [15:0] m_presc;
    int          m_cnt;
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [31:0] m_rdata;
    logic        m_irq;

    logic [31:0] rst_exp [8];

    mtimer_slave #(
        .ADDR_WIDTH  (8),
        .PRESC_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_we        (i_we),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .i_wstrb     (i_wstrb),
        .i_re        (i_re),
        .i_raddr     (i_raddr),
        .o_rdata     (o_rdata),
        .o_timer_irq (o_timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case ({a[7:2], 2'b00})
            8'h00:   return {31'b0, m_en};
            8'h04:   return {16'b0, m_presc};
            8'h08:   return m_mtime[31:0];
            8'h0C:   return m_shadow;
            8'h10:   return m_cmp[31:0];
            8'h14:   return m_cmp[63:32];
            8'h18:   return {31'b0, (m_mtime >= m_cmp)};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the timer, computed from the pre-edge model state.
    task automatic model_edge(input bit r, input bit we, input logic [7:0] wa,
                              input logic [31:0] wd, input logic [3:0] ws,
                              input bit re, input logic [7:0] ra);
        logic [63:0] old_t;
        bit          tick;
        if (r) begin
            m_en = 0; m_presc = 0; m_cnt = 0; m_mtime = 0;
            m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 0; m_rdata = 0; m_irq = 0;
            return;
        end
        old_t = m_mtime;
        tick  = m_en && (m_cnt == int'(m_presc));
        if (re) begin
            m_rdata = model_read(ra);
            if ({ra[7:2], 2'b00} == 8'h08) m_shadow = old_t[63:32];
        end
        m_irq = m_en && (old_t >= m_cmp);
        m_cnt = (m_en && !tick) ? m_cnt + 1 : 0;
        if (tick) m_mtime = old_t + 64'd1;
        if (we && ws != 4'b0) begin
            case ({wa[7:2], 2'b00})
                8'h00: begin if (ws[0]) m_en = wd[0]; m_cnt = 0; end
                8'h04: begin m_presc = 16'(merge({16'b0, m_presc}, wd, ws)); m_cnt = 0; end
                8'h08: m_mtime = {old_t[63:32], merge(old_t[31:0], wd, ws)};
                8'h0C: m_mtime = {merge(old_t[63:32], wd, ws), old_t[31:0]};
                8'h10: m_cmp[31:0]  = merge(m_cmp[31:0], wd, ws);
                8'h14: m_cmp[63:32] = merge(m_cmp[63:32], wd, ws);
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit we, input logic [7:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input bit re, input logic [7:0] ra);
        rst = r; i_we = we; i_waddr = wa; i_wdata = wd; i_wstrb = ws; i_re = re; i_raddr = ra;
        @(posedge clk);
        model_edge(r, we, wa, wd, ws, re, ra);
        #1;
        rst = 1'b0; i_we = 1'b0; i_re = 1'b0;
        check("model_rdata", o_rdata, m_rdata);
        check("model_irq", {31'b0, o_timer_irq}, {31'b0, m_irq});
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(0, 1, a, d, 4'hF, 0, 8'h0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(0, 0, 8'h0, 32'h0, 4'h0, 1, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h0, 32'h0, 4'h0, 0, 8'h0);
    endtask

    task automatic check_reset_map(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd(8'(i * 4));
            check(tag, o_rdata, rst_exp[i]);
        end
        check({tag, "_irq"}, {31'b0, o_timer_irq}, 32'h0);
    endtask

    initial begin
        rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

        // Reset
        step(1, 0, 8'h0, 32'h0, 4'h0, 0, 8'h0);
        step(1, 0, 8'h0, 32'h0, 4'h0, 0, 8'h0);
        check("reset_rdata", o_rdata, 32'h0);
        check_reset_map("reset_map");

        // Prescaler divide-by-4
        wr(8'h04, 32'd3);
        wr(8'h00, 32'd1);
        idle(40);
        rd(8'h08);
        check("presc_mtime", o_rdata, 32'd10);
        wr(8'h00, 32'd0);
        rd(8'h08);
        check("hold_a", o_rdata, 32'd10);
        idle(20);
        rd(8'h08);
        check("hold_b", o_rdata, 32'd10);

        // Wrap and atomic 64-bit read
        wr(8'h0C, 32'hFFFF_FFFF);
        wr(8'h08, 32'hFFFF_FFFE);
        wr(8'h04, 32'd0);
        wr(8'h00, 32'd1);
        rd(8'h08);
        check("wrap_lo", o_rdata, 32'hFFFF_FFFE);
        rd(8'h0C);
        check("wrap_shadow_hi", o_rdata, 32'hFFFF_FFFF);
        rd(8'h08);
        check("wrapped_lo", o_rdata, 32'h0);
        rd(8'h0C);
        check("wrapped_hi", o_rdata, 32'h0);

        // Compare and interrupt timing
        wr(8'h00, 32'd0);
        wr(8'h08, 32'd0);
        wr(8'h0C, 32'd0);
        wr(8'h14, 32'd0);
        wr(8'h10, 32'd5);
        wr(8'h04, 32'd0);
        wr(8'h00, 32'd1);
        idle(5);
        check("irq_before", {31'b0, o_timer_irq}, 32'h0);
        idle(1);
        check("irq_rise", {31'b0, o_timer_irq}, 32'h1);
        rd(8'h18);
        check("status_hit", o_rdata, 32'h1);
        wr(8'h10, 32'hFFFF_FFFF);
        check("irq_hold", {31'b0, o_timer_irq}, 32'h1);
        wr(8'h14, 32'hFFFF_FFFF);
        check("irq_fall", {31'b0, o_timer_irq}, 32'h0);
        rd(8'h18);
        check("status_clear", o_rdata, 32'h0);

        // Byte strobes
        step(0, 1, 8'h10, 32'hAABB_CCDD, 4'b0101, 0, 8'h0);
        rd(8'h10);
        check("strobe_0101", o_rdata, 32'hFFBB_FFDD);
        step(0, 1, 8'h10, 32'h1234_5678, 4'b0000, 0, 8'h0);
        rd(8'h10);
        check("strobe_none", o_rdata, 32'hFFBB_FFDD);

        // Collisions
        wr(8'h08, 32'h100);
        rd(8'h08);
        check("tick_collide", o_rdata, 32'h100);
        rd(8'h08);
        check("after_collide", o_rdata, 32'h101);
        step(0, 1, 8'h04, 32'd7, 4'hF, 1, 8'h04);
        check("rw_same_old", o_rdata, 32'h0);
        rd(8'h04);
        check("rw_same_new", o_rdata, 32'd7);
        rd(8'h40);
        check("unmapped", o_rdata, 32'h0);
        idle(3);
        step(1, 1, 8'h08, 32'h55, 4'hF, 1, 8'h08);
        check("midrst_rdata", o_rdata, 32'h0);
        check_reset_map("midrst_map");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit          r, we, re;
            int          pick;
            logic [7:0]  wa, ra;
            logic [31:0] wd;
            r    = ($urandom_range(0, 199) == 0);
            we   = $urandom_range(0, 1) == 1;
            re   = $urandom_range(0, 1) == 1;
            pick = $urandom_range(0, 9);
            wa   = (pick < 8) ? 8'(pick * 4) : 8'($urandom_range(8, 63) * 4);
            ra   = 8'($urandom_range(0, 9) * 4) | 8'($urandom_range(0, 3));
            wd   = $urandom;
            if (wa == 8'h00 || wa == 8'h04) wd = $urandom_range(0, 3);
            if (wa == 8'h0C || wa == 8'h14) wd = $urandom_range(0, 1);
            if (wa == 8'h08 || wa == 8'h10) wd = $urandom_range(0, 40);
            step(r, we, wa | 8'($urandom_range(0, 3)), wd, 4'($urandom_range(0, 15)), re, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
